// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampling UART receiver feeding the COMCONT command FIFO.
//
// The rx line is synchronised, then sampled OVERSAMPLE times per bit. Each bit
// is decided by a 3-sample majority vote around the bit centre. Frame format
// is configurable: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// and LSB- or MSB-first bit order. Errors are kept in sticky status bits.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   fifoData   received word; the first line bit lands at index 0 (LSBFIRST)
//   fifoWrite  one-cycle write strobe into the downstream FIFO
//   fifoFull   downstream FIFO full; a completed frame is dropped (overrun)
//   errClear   clears all sticky error bits
//   error      sticky {BREAK, OVERRUN, PARITY, FRAMING}
//   busy       high whenever the receiver is not idle
module uart_rx_os #(
    parameter int    CLKFREQUENCY = 100_000_000,
    parameter int    BAUDRATE     = 9600,
    parameter int    OVERSAMPLE   = 16,
    parameter int    DATABITS     = 8,
    parameter string PARITY       = "NONE",
    parameter int    STOPBITS     = 1,
    parameter string SHIFT        = "LSBFIRST",
    parameter int    SYNCSTAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [DATABITS-1:0] fifoData,
    output logic                fifoWrite,
    input  logic                fifoFull,
    input  logic                errClear,
    output logic [3:0]          error,
    output logic                busy
);

    localparam int TICKDIV   = CLKFREQUENCY / (BAUDRATE * OVERSAMPLE);
    localparam int DIVW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam int SW        = $clog2(OVERSAMPLE);
    localparam int BW        = $clog2(DATABITS + 1);
    localparam int H         = OVERSAMPLE / 2;
    localparam bit PAR_EN    = (PARITY != "NONE");
    localparam bit PAR_ODD   = (PARITY == "ODD");
    localparam bit MSB_FIRST = (SHIFT == "MSBFIRST");

    // Elaboration-time parameter sanity checks.
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if (DATABITS < 5 || DATABITS > 9) begin : g_chk_db
        $error("uart_rx_os: DATABITS must be 5..9");
    end
    if (STOPBITS < 1 || STOPBITS > 2) begin : g_chk_sb
        $error("uart_rx_os: STOPBITS must be 1 or 2");
    end
    if (SYNCSTAGES < 2) begin : g_chk_sync
        $error("uart_rx_os: SYNCSTAGES must be >= 2");
    end
    if (TICKDIV < 1) begin : g_chk_div
        $error("uart_rx_os: clock too slow for BAUDRATE*OVERSAMPLE");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_WAITIDLE = 3'd5
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Input synchroniser; preset to idle-high so reset never looks like a
    // start bit.
    // ------------------------------------------------------------------
    logic [SYNCSTAGES-1:0] sync_q;
    logic                  rx_s;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNCSTAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNCSTAGES-1];

    // ------------------------------------------------------------------
    // Oversample tick divider and per-bit sample counter. Both restart on
    // the start-bit edge so every bit is sampled relative to that edge.
    // ------------------------------------------------------------------
    logic [DIVW-1:0] div_cnt;
    logic [SW-1:0]   s_cnt;
    logic            tick;
    logic            start_frame;

    assign tick = (div_cnt == DIVW'(TICKDIV - 1));

    always_ff @(posedge clk) begin
        if (rst || start_frame) begin
            div_cnt <= '0;
            s_cnt   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            s_cnt   <= (s_cnt == SW'(OVERSAMPLE - 1)) ? '0 : s_cnt + SW'(1);
        end else begin
            div_cnt <= div_cnt + DIVW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Majority vote: two early samples are stored, the third is the live
    // synchronised value on the deciding tick.
    // ------------------------------------------------------------------
    logic v0, v1, vote;
    logic dec_tick, end_tick;

    assign dec_tick = tick && (s_cnt == SW'(H + 1));
    assign end_tick = tick && (s_cnt == SW'(OVERSAMPLE - 1));
    assign vote     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b1;
            v1 <= 1'b1;
        end else begin
            if (tick && s_cnt == SW'(H - 1)) v0 <= rx_s;
            if (tick && s_cnt == SW'(H))     v1 <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------
    logic [DATABITS-1:0] data_sh, data_shifted;
    logic [BW-1:0]       bit_cnt;
    logic                par_bit, par_bad, par_exp;
    logic                frm_bad, stop0_zero, stop_cnt;
    logic                last_stop, first_stop_zero, frm_now, brk;
    logic                shift_en, par_chk, stop_dec, stop_adv, complete;
    logic [3:0]          err_set;

    if (MSB_FIRST) begin : g_msb
        assign data_shifted = {data_sh[DATABITS-2:0], vote};
    end else begin : g_lsb
        assign data_shifted = {vote, data_sh[DATABITS-1:1]};
    end

    assign par_exp   = PAR_ODD ? ~^data_sh : ^data_sh;
    assign last_stop = (STOPBITS == 1) || stop_cnt;
    // With one stop bit the first stop bit is the one being decided now.
    assign first_stop_zero = (STOPBITS == 1) ? ~vote : stop0_zero;
    assign frm_now   = frm_bad | ~vote;
    assign brk       = (data_sh == '0) && (!PAR_EN || !par_bit) && first_stop_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_sh    <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            par_bad    <= 1'b0;
            frm_bad    <= 1'b0;
            stop0_zero <= 1'b0;
            stop_cnt   <= 1'b0;
        end else begin
            if (start_frame) begin
                data_sh    <= '0;
                bit_cnt    <= '0;
                par_bit    <= 1'b0;
                par_bad    <= 1'b0;
                frm_bad    <= 1'b0;
                stop0_zero <= 1'b0;
                stop_cnt   <= 1'b0;
            end
            if (shift_en) begin
                data_sh <= data_shifted;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (par_chk) begin
                par_bit <= vote;
                par_bad <= (vote != par_exp);
            end
            if (stop_dec) begin
                if (!vote)      frm_bad    <= 1'b1;
                if (!last_stop) stop0_zero <= ~vote;
            end
            if (stop_adv) stop_cnt <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_chk     = 1'b0;
        stop_dec    = 1'b0;
        stop_adv    = 1'b0;
        complete    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next  = S_START;
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch: drop it silently.
                if (dec_tick && vote) state_next = S_IDLE;
                else if (end_tick)    state_next = S_DATA;
            end
            S_DATA: begin
                if (dec_tick) shift_en = 1'b1;
                if (end_tick && bit_cnt == BW'(DATABITS))
                    state_next = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (dec_tick) par_chk = 1'b1;
                if (end_tick) state_next = S_STOP;
            end
            S_STOP: begin
                // Finish at the decision point of the last stop bit so the
                // next start edge is never missed.
                if (dec_tick) begin
                    stop_dec = 1'b1;
                    if (last_stop) begin
                        complete   = 1'b1;
                        state_next = brk ? S_WAITIDLE : S_IDLE;
                    end
                end else if (end_tick) begin
                    stop_adv = 1'b1;
                end
            end
            S_WAITIDLE: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame completion and sticky errors
    // ------------------------------------------------------------------
    always_comb begin
        err_set = 4'b0000;
        if (complete) begin
            if (brk)           err_set[3] = 1'b1;
            else if (fifoFull) err_set[2] = 1'b1;
            else begin
                err_set[1] = par_bad;
                err_set[0] = frm_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifoData  <= '0;
            fifoWrite <= 1'b0;
            error     <= 4'b0000;
        end else begin
            fifoWrite <= 1'b0;
            // OR-ing set events after the clear lets a same-cycle set win.
            error     <= (errClear ? 4'b0000 : error) | err_set;
            if (complete && !brk && !fifoFull) begin
                fifoData  <= data_sh;
                fifoWrite <= 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

    localparam int CLKF   = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int OS     = 16;
    localparam int BITCLK = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic full = 1'b0;
    logic clr = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic [7:0] data0, data1, data2;
    logic       wr0, wr1, wr2;
    logic [3:0] err0, err1, err2;
    logic       busy0, busy1, busy2;

    int errors = 0;
    int checks = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    // 8N1 LSB-first
    uart_rx_os #(.CLKFREQUENCY(CLKF), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATABITS(8),
                 .PARITY("NONE"), .STOPBITS(1), .SHIFT("LSBFIRST"), .SYNCSTAGES(2)) d0 (
        .clk(clk), .rst(rst), .rx(rx0), .fifoData(data0), .fifoWrite(wr0),
        .fifoFull(full), .errClear(clr), .error(err0), .busy(busy0));

    // 8E1 LSB-first
    uart_rx_os #(.CLKFREQUENCY(CLKF), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATABITS(8),
                 .PARITY("EVEN"), .STOPBITS(1), .SHIFT("LSBFIRST"), .SYNCSTAGES(2)) d1 (
        .clk(clk), .rst(rst), .rx(rx1), .fifoData(data1), .fifoWrite(wr1),
        .fifoFull(full), .errClear(clr), .error(err1), .busy(busy1));

    // 8N2 MSB-first
    uart_rx_os #(.CLKFREQUENCY(CLKF), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATABITS(8),
                 .PARITY("NONE"), .STOPBITS(2), .SHIFT("MSBFIRST"), .SYNCSTAGES(2)) d2 (
        .clk(clk), .rst(rst), .rx(rx2), .fifoData(data2), .fifoWrite(wr2),
        .fifoFull(full), .errClear(clr), .error(err2), .busy(busy2));

    // One clock; afterwards every write strobe is matched against the scoreboard.
    task automatic cyc();
        logic [7:0] exp;
        @(posedge clk);
        #1;
        if (wr0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++; $display("FAIL d0_unexpected_write got=%h want=none", data0);
            end else begin
                exp = q0.pop_front();
                if (data0 !== exp) begin errors++; $display("FAIL d0_data got=%h want=%h", data0, exp); end
            end
        end
        if (wr1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++; $display("FAIL d1_unexpected_write got=%h want=none", data1);
            end else begin
                exp = q1.pop_front();
                if (data1 !== exp) begin errors++; $display("FAIL d1_data got=%h want=%h", data1, exp); end
            end
        end
        if (wr2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++; $display("FAIL d2_unexpected_write got=%h want=none", data2);
            end else begin
                exp = q2.pop_front();
                if (data2 !== exp) begin errors++; $display("FAIL d2_data got=%h want=%h", data2, exp); end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_rx(input int ln, input logic v);
        case (ln)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Drive nb line bits, bits[0] first, then return the line to idle.
    task automatic send(input int ln, input logic [15:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            set_rx(ln, bits[i]);
            wait_cycles(BITCLK);
        end
        set_rx(ln, 1'b1);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
        return {6'b111111, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic p);
        return {5'b11111, 1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8n2msb(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return {5'b11111, 2'b11, r, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        checks++;
        if ({data0, wr0, err0, busy0} !== 14'b0) begin
            errors++; $display("FAIL reset_d0 got=%h/%b/%b/%b want=0", data0, wr0, err0, busy0);
        end
        checks++;
        if ({data1, wr1, err1, busy1} !== 14'b0) begin
            errors++; $display("FAIL reset_d1 got=%h/%b/%b/%b want=0", data1, wr1, err1, busy1);
        end
        checks++;
        if ({data2, wr2, err2, busy2} !== 14'b0) begin
            errors++; $display("FAIL reset_d2 got=%h/%b/%b/%b want=0", data2, wr2, err2, busy2);
        end
        rst = 1'b0;
        wait_cycles(5);
    endtask

    task automatic test_8n1();
        q0.push_back(8'hA5);
        send(0, f8n1(8'hA5, 1'b1), 10);
        wait_cycles(20);
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL 8n1_written got=%0d pending want=0", q0.size()); end
        checks++;
        if (err0 !== 4'b0000) begin errors++; $display("FAIL 8n1_error got=%b want=0000", err0); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL 8n1_busy got=%b want=0", busy0); end
    endtask

    task automatic test_parity();
        q1.push_back(8'h03);
        send(1, f8e1(8'h03, 1'b1), 11);
        wait_cycles(20);
        checks++;
        if (q1.size() != 0) begin errors++; $display("FAIL parity_written got=%0d pending want=0", q1.size()); end
        checks++;
        if (err1 !== 4'b0010) begin errors++; $display("FAIL parity_error got=%b want=0010", err1); end
        pulse_clear();
        checks++;
        if (err1 !== 4'b0000) begin errors++; $display("FAIL parity_clear got=%b want=0000", err1); end
    endtask

    task automatic test_glitch();
        rx0 = 1'b0;
        wait_cycles(20);
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got=%b want=1", busy0); end
        wait_cycles(20);
        rx0 = 1'b1;
        wait_cycles(200);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b want=0", busy0); end
        checks++;
        if (err0 !== 4'b0000) begin errors++; $display("FAIL glitch_error got=%b want=0000", err0); end
    endtask

    task automatic test_framing_break();
        q0.push_back(8'h55);
        send(0, f8n1(8'h55, 1'b0), 10);
        wait_cycles(40);
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL framing_written got=%0d pending want=0", q0.size()); end
        checks++;
        if (err0 !== 4'b0001) begin errors++; $display("FAIL framing_error got=%b want=0001", err0); end
        pulse_clear();
        rx0 = 1'b0;
        wait_cycles(12 * BITCLK);
        checks++;
        if (err0 !== 4'b1000) begin errors++; $display("FAIL break_error got=%b want=1000", err0); end
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL break_waitidle got=%b want=1", busy0); end
        rx0 = 1'b1;
        wait_cycles(20);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL break_release got=%b want=0", busy0); end
        pulse_clear();
    endtask

    task automatic test_overrun();
        full = 1'b1;
        send(0, f8n1(8'h7E, 1'b1), 10);
        wait_cycles(20);
        full = 1'b0;
        checks++;
        if (err0 !== 4'b0100) begin errors++; $display("FAIL overrun_error got=%b want=0100", err0); end
        pulse_clear();
        checks++;
        if (err0 !== 4'b0000) begin errors++; $display("FAIL overrun_clear got=%b want=0000", err0); end
        q0.push_back(8'h81);
        send(0, f8n1(8'h81, 1'b1), 10);
        wait_cycles(20);
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL overrun_recover got=%0d pending want=0", q0.size()); end
        checks++;
        if (err0 !== 4'b0000) begin errors++; $display("FAIL overrun_recover_err got=%b want=0000", err0); end
    endtask

    task automatic test_back_to_back();
        q2.push_back(8'h11);
        q2.push_back(8'h22);
        q2.push_back(8'h33);
        send(2, f8n2msb(8'h11), 11);
        send(2, f8n2msb(8'h22), 11);
        send(2, f8n2msb(8'h33), 11);
        wait_cycles(20);
        checks++;
        if (q2.size() != 0) begin errors++; $display("FAIL b2b_written got=%0d pending want=0", q2.size()); end
        checks++;
        if (err2 !== 4'b0000) begin errors++; $display("FAIL b2b_error got=%b want=0000", err2); end
        // Reset in the middle of the second frame.
        q2.push_back(8'h11);
        send(2, f8n2msb(8'h11), 11);
        send(2, f8n2msb(8'h22), 5);
        rst = 1'b1;
        wait_cycles(3);
        checks++;
        if ({data2, wr2, err2, busy2} !== 14'b0) begin
            errors++; $display("FAIL b2b_reset got=%h/%b/%b/%b want=0", data2, wr2, err2, busy2);
        end
        rst = 1'b0;
        wait_cycles(2000);
        checks++;
        if (q2.size() != 0) begin errors++; $display("FAIL b2b_pre_reset got=%0d pending want=0", q2.size()); end
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL b2b_after_reset got=%b want=0", busy2); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_framing_break();
        test_overrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
